serial_sub_4b: RTL and testbench
================================

SERIAL_SUB_4B -- requirements
Module: serial_sub_4b

Interface
- REQ-001 SHALL have parameter WIDTH, default 4: operand/result width in bits (legal 2..16).
- REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on posedge clk.
- REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
- REQ-004 SHALL have port start, input, 1 bit: request to begin one subtraction.
- REQ-005 SHALL have port a, input, WIDTH bits: minuend, sampled with start.
- REQ-006 SHALL have port b, input, WIDTH bits: subtrahend, sampled with start.
- REQ-007 SHALL have port busy, output reg, 1 bit: high while bits are being processed.
- REQ-008 SHALL have port done, output reg, 1 bit: one-cycle pulse when diff/borrow are updated.
- REQ-009 SHALL have port diff, output reg, WIDTH bits: a - b modulo 2^WIDTH.
- REQ-010 SHALL have port borrow, output reg, 1 bit: 1 when a < b (unsigned).

Function
- REQ-011 SHALL implement FSM states IDLE, CALC and DONE.
- REQ-012 In IDLE, start=1 at a posedge SHALL:
  - latch a and b;
  - set the internal carry to 1 (two's complement: a + ~b + 1);
  - clear the bit counter;
  - go to CALC.
- REQ-013 In CALC, each posedge SHALL process one bit, LSB first.
  - Full-adder inputs: a_bit, ~b_bit, carry.
  - The sum bit SHALL shift into the result register from the MSB side.
  - The carry register SHALL take the full-adder carry out.
  - The counter SHALL increment.
- REQ-014 After the posedge that processes bit WIDTH-1, the FSM SHALL go to DONE.
  - On that posedge, diff SHALL load the completed result.
  - On that posedge, borrow SHALL load the inverse of the final carry.
- REQ-015 DONE SHALL last exactly one cycle, then return to IDLE unconditionally.
- REQ-016 Latency: with start sampled at edge k, done SHALL be high in exactly the cycle following edge k+WIDTH, and low otherwise.
- REQ-017 busy SHALL be high exactly while the state is CALC.
- REQ-018 start SHALL be ignored in CALC and DONE; it is neither queued nor able to corrupt latched operands.
- REQ-019 diff and borrow SHALL hold their last values until the next DONE; they SHALL not change during CALC.
- REQ-020 Back-to-back operation: start high in the IDLE cycle immediately after DONE SHALL be accepted, giving a throughput of one result per WIDTH+2 cycles.

Reset
- REQ-021 When rst=1 at a posedge:
  - state SHALL go to IDLE;
  - busy, done, borrow SHALL be 0;
  - diff SHALL be 0;
  - counter, carry and operand registers SHALL be cleared.
- REQ-022 rst SHALL take priority over start in the same cycle.
- REQ-023 rst asserted mid-CALC SHALL abort the operation.
  - No done pulse SHALL follow.
  - The first start after rst deassertion SHALL be accepted normally.

Configuration
- REQ-024 With SERIAL_SUB_4B_OVF_EN defined, an output reg ovf (1 bit) SHALL be present.
  - ovf loads at the same edge as diff.
  - ovf SHALL be 1 when signed two's-complement overflow occurs, i.e. the carry into the MSB differs from the carry out of the MSB.
  - ovf resets to 0.
- REQ-025 Without SERIAL_SUB_4B_OVF_EN, the ovf port and its logic SHALL be absent; all other behaviour is identical.

Structure
- REQ-026 A shared package serial_sub_pkg SHALL hold:
  - the FSM state encoding (IDLE=2'd0, CALC=2'd1, DONE=2'd2);
  - the default width constant (4).
- REQ-027 The one-bit arithmetic SHALL be one instance of the existing full_adder sub-module; no other sub-modules.

Verification
- REQ-028 a=9, b=4, start pulse -> done 4 cycles after the start edge; diff=5, borrow=0; busy high for exactly 4 cycles.
- REQ-029 a=4, b=9 -> diff=4'hB, borrow=1; a=0, b=0 -> diff=0, borrow=0; a=4'hF, b=4'hF -> diff=0, borrow=0.
- REQ-030 a=3, b=1, start, then start again with a=8, b=8 during CALC -> single done, diff=2; the second request is ignored.
- REQ-031 Reset mid-operation: start with a=7, b=2, rst at the second CALC cycle -> no done, all outputs 0. Then a=7, b=2 -> diff=5, borrow=0.
- REQ-032 With SERIAL_SUB_4B_OVF_EN:
  - a=4'h7, b=4'h8 -> diff=4'hF, ovf=1, borrow=1;
  - a=4'h8, b=4'h1 -> diff=4'h7, ovf=1;
  - a=5, b=3 -> ovf=0.
- REQ-033 Back-to-back: start asserted in the IDLE cycle right after DONE -> second done exactly 6 cycles after the first (WIDTH=4); both results correct.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and default width.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder used as the serial arithmetic slice.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_sub_4b.sv
// Bit-serial unsigned subtractor (a + ~b + 1), one bit per clock, LSB first.
// Optional signed-overflow output ovf is built when SERIAL_SUB_4B_OVF_EN is defined.
module serial_sub_4b
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
`ifdef SERIAL_SUB_4B_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] res;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             fa_sum;
    logic             fa_cout;
    logic             last_bit;

    full_adder u_fa (
        .a    (a_r[0]),
        .b    (~b_r[0]),
        .cin  (carry),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    assign last_bit = (state == CALC) && (cnt == CW'(WIDTH - 1));

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CALC;
            CALC:    if (last_bit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // busy/done are registered copies of the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            diff   <= '0;
            borrow <= 1'b0;
            a_r    <= '0;
            b_r    <= '0;
            res    <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
`ifdef SERIAL_SUB_4B_OVF_EN
            ovf    <= 1'b0;
`endif
        end else begin
            state <= state_next;
            busy  <= (state_next == CALC);
            done  <= (state_next == DONE);
            case (state)
                IDLE: begin
                    if (start) begin
                        a_r   <= a;
                        b_r   <= b;
                        carry <= 1'b1;
                        cnt   <= '0;
                    end
                end
                CALC: begin
                    a_r   <= a_r >> 1;
                    b_r   <= b_r >> 1;
                    res   <= {fa_sum, res[WIDTH-1:1]};
                    carry <= fa_cout;
                    cnt   <= cnt + 1'b1;
                    if (last_bit) begin
                        diff   <= {fa_sum, res[WIDTH-1:1]};
                        borrow <= ~fa_cout;
`ifdef SERIAL_SUB_4B_OVF_EN
                        // carry register holds the carry into the MSB at this point
                        ovf    <= carry ^ fa_cout;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub_4b.sv
// Directed self-checking bench for serial_sub_4b (WIDTH=4); ovf checks built with SERIAL_SUB_4B_OVF_EN.
module tb_serial_sub_4b;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;
`ifdef SERIAL_SUB_4B_OVF_EN
    logic             ovf;
`endif

    int checks = 0;
    int errors = 0;

    serial_sub_4b #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .borrow (borrow)
`ifdef SERIAL_SUB_4B_OVF_EN
        ,
        .ovf    (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Start one operation and follow it to its done pulse; inputs change on negedges.
    task automatic run_op(input string tag, input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                          input logic [WIDTH-1:0] exp_diff, input logic exp_borrow, input logic exp_ovf);
        logic [WIDTH-1:0] prev;
        int lat;
        int busy_n;
        prev   = diff;
        lat    = 0;
        busy_n = 0;
        @(negedge clk);
        a = ta; b = tb_v; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!done && lat < 20) begin
            if (busy) busy_n++;
            check({tag, "_hold"}, 32'(diff), 32'(prev));
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'd4);
        check({tag, "_busy_cycles"}, 32'(busy_n), 32'd4);
        check({tag, "_diff"}, 32'(diff), 32'(exp_diff));
        check({tag, "_borrow"}, 32'(borrow), 32'(exp_borrow));
`ifdef SERIAL_SUB_4B_OVF_EN
        check({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
`else
        if (exp_ovf === 1'bx) check({tag, "_ovf_arg"}, 32'(exp_ovf), 32'd0);
`endif
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        int n_done;
        int gap;
        rst = 1'b1; start = 1'b0; a = '0; b = '0;

        // Reset state, with start held to show reset wins.
        @(negedge clk);
        start = 1'b1; a = 4'd9; b = 4'd4;
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_diff", 32'(diff), 32'd0);
        check("rst_borrow", 32'(borrow), 32'd0);
`ifdef SERIAL_SUB_4B_OVF_EN
        check("rst_ovf", 32'(ovf), 32'd0);
`endif
        rst = 1'b0; start = 1'b0;

        run_op("9m4", 4'd9, 4'd4, 4'd5, 1'b0, 1'b1);
        run_op("4m9", 4'd4, 4'd9, 4'hB, 1'b1, 1'b1);
        run_op("0m0", 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
        run_op("FmF", 4'hF, 4'hF, 4'd0, 1'b0, 1'b0);
        run_op("7m8", 4'h7, 4'h8, 4'hF, 1'b1, 1'b1);
        run_op("8m1", 4'h8, 4'h1, 4'h7, 1'b0, 1'b1);
        run_op("5m3", 4'd5, 4'd3, 4'd2, 1'b0, 1'b0);

        // Start during CALC must be ignored.
        @(negedge clk);
        a = 4'd3; b = 4'd1; start = 1'b1;
        @(negedge clk);
        a = 4'd8; b = 4'd8;
        @(negedge clk);
        start = 1'b0;
        n_done = 0;
        gap = 0;
        while (!done && gap < 20) begin @(negedge clk); gap++; end
        check("ign_diff", 32'(diff), 32'd2);
        check("ign_borrow", 32'(borrow), 32'd0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done || busy) n_done++;
        end
        check("ign_no_second", 32'(n_done), 32'd0);

        // Reset in the second CALC cycle aborts the operation.
        @(negedge clk);
        a = 4'd7; b = 4'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_diff", 32'(diff), 32'd0);
        check("abort_borrow", 32'(borrow), 32'd0);
        n_done = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done || busy) n_done++;
        end
        check("abort_quiet", 32'(n_done), 32'd0);
        run_op("7m2", 4'd7, 4'd2, 4'd5, 1'b0, 1'b0);

        // Back-to-back: second start in the IDLE cycle right after DONE.
        @(negedge clk);
        a = 4'd9; b = 4'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        gap = 0;
        while (!done && gap < 20) begin @(negedge clk); gap++; end
        check("b2b_first_diff", 32'(diff), 32'd5);
        gap = 0;
        @(negedge clk);
        gap++;
        a = 4'd2; b = 4'd5; start = 1'b1;
        @(negedge clk);
        gap++;
        start = 1'b0;
        while (!done && gap < 30) begin @(negedge clk); gap++; end
        check("b2b_gap", 32'(gap), 32'd6);
        check("b2b_second_diff", 32'(diff), 32'hD);
        check("b2b_second_borrow", 32'(borrow), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
